fft_in_buf: RTL and testbench
=============================

# fft_in_buf

Ping-pong frame buffer feeding the FFT processor's input port. Accepts NUBITS-wide float samples on a valid/ready stream, collects frames of 2^FFTSIZ samples, and interrupts the processor with a one-cycle `itr` pulse when a frame is ready. It then serves the samples on `io_in`, one per `req_in` strobe. Sits between the sample source and the processor's `io_in`/`req_in`/`itr` ports.

## Interface
- NUBITS, 32, sample width (float word).
- FFTSIZ, 3, log2 of frame length; N = 2^FFTSIZ samples per frame.
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- s_data  input  NUBITS  incoming sample.
- s_valid  input  1  `s_data` valid.
- s_ready  output  1  buffer can accept a sample this cycle.
- io_in  output  NUBITS  sample presented to the processor.
- req_in  input  1  processor read strobe; consumes the current `io_in` word.
- itr  output  1  frame-ready interrupt, one-cycle pulse.
- und  output  1  sticky underrun: `req_in` seen while no frame is being served.

## Operation
- Two banks of N words each, with flags `full[0..1]`, write bank pointer `wr_bank` and read bank pointer `rd_bank`.
- Write side:
  - Handshake when `s_valid && s_ready`; `s_ready = !full[wr_bank]`.
  - Word is written at `wr_ptr`, then `wr_ptr` increments.
  - On the N-th word: `full[wr_bank]<=1`, `wr_ptr<=0`, `wr_bank` toggles.
- Read-side FSM:
  - IDLE: if `full[rd_bank]`, go to ARMED.
  - ARMED: `itr=1` for this one cycle; go to SERVE.
  - SERVE: `io_in = bank[rd_bank][addr(rd_ptr)]`. Each cycle with `req_in=1` increments `rd_ptr`. When the N-th read occurs: `full[rd_bank]<=0`, `rd_ptr<=0`, `rd_bank` toggles, go to IDLE.
- `io_in` is 0 outside SERVE.
- `req_in` in IDLE or ARMED: ignored (no pointer change) and sets `und`. `und` is cleared only by reset.
- Writer and reader never touch the same bank: the writer needs a not-full bank, the reader a full one. Setting `full` on one bank and clearing it on the other in the same cycle are independent and both take effect.
- Both banks full: `s_ready=0`, and the source stalls. No data is dropped.

## Timing
- Reset values: `s_ready=1`, `itr=0`, `io_in=0`, `und=0`, FSM=IDLE, all pointers 0, both `full` flags 0.
- Reset mid-operation clears everything; any partial or unread frame is discarded.
- Write: one sample per cycle max. `s_ready` is combinational from registered flags, with no dependence on `s_valid`.
- Interrupt latency: last-sample handshake at edge E0 → state ARMED after edge E1 (`itr` high for E1–E2) → SERVE after E2.
- Read: `io_in` is valid combinationally in SERVE. A `req_in` in cycle k consumes that word; the next word appears after the edge.
- Back-to-back frames: after the last read, IDLE lasts ≥1 cycle, so consecutive `itr` pulses are ≥ N+2 cycles apart.

## Configuration
- `FFT_IN_BITREV_EN` defined: `addr(rd_ptr)` = FFTSIZ-bit reversal of `rd_ptr`. Samples are served in bit-reversed order for an in-place DIT FFT; for N=8 the order is 0,4,2,6,1,5,3,7.
- Undefined: `addr(rd_ptr) = rd_ptr`, natural order.
- The write side is unaffected in both cases.

## Structure
- Shared package `fft_in_pkg`:
  - FSM state encodings (IDLE, ARMED, SERVE).
  - bit-reverse function, parameterised by FFTSIZ.
- Sub-module `fft_in_bank`:
  - N×NUBITS register array.
  - synchronous write port (`we`, `waddr`, `wdata`).
  - asynchronous read port.
  - instantiated twice.
- Top level holds the flags, pointers and FSM.

## Test plan
- Reset, then push 8 samples 1..8 back-to-back → `itr` is high exactly one cycle, 2 cycles after the 8th handshake. With 8 `req_in` strobes, `io_in` = 1..8 (natural) or 1,5,3,7,2,6,4,8 (bitrev).
- Push 16 samples with no reads → `s_ready` drops after the 16th. Reading frame 1 re-asserts `s_ready` the cycle after the last read. A second `itr` fires, and frame 2 = 9..16.
- Writing frame 3 while serving frame 2 → no corruption of frame 2 values; `s_ready` stays high throughout.
- `req_in=1` in IDLE → `und=1` and stays 1. The following valid frame is still served intact.
- Assert `rst` after 5 reads of a full frame → all outputs return to reset values, and no `itr` fires until 8 new samples arrive.
- `req_in` held high continuously in SERVE → exactly 8 words are consumed, then IDLE. An extra strobe while in IDLE sets `und`.

Source files
------------

// File: rtl/fft_in_pkg.sv
// ============================================================================
// Module      : fft_in_pkg
// Description : Shared definitions for the FFT input ping-pong buffer:
//               read-side FSM state encoding and a bit-reversal helper used
//               to produce in-place DIT read ordering.
//               Optional feature macro: FFT_IN_BITREV_EN (used by fft_in_buf).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fft_in_pkg;

    // Read-side FSM states. Explicit 2-bit encoding; the spare code 2'b11
    // is treated as IDLE by the next-state logic.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SERVE = 2'd2
    } fft_in_state_t;

    // Widest index the bit-reversal helper supports (frames up to 64K words).
    localparam int c_BITREV_MAX_W = 16;

    // Reverse the low 'width' bits of 'value'; bits above 'width' return 0.
    // Callers pass their own FFTSIZ as 'width' and truncate the result.
    function automatic logic [c_BITREV_MAX_W-1:0] bit_rev(
        input logic [c_BITREV_MAX_W-1:0] value,
        input int                        width
    );
        logic [c_BITREV_MAX_W-1:0] result;
        result = '0;
        for (int i = 0; i < c_BITREV_MAX_W; i++) begin
            if (i < width) begin
                result[i] = value[width-1-i];
            end
        end
        return result;
    endfunction

endpackage : fft_in_pkg

`default_nettype wire

// File: rtl/fft_in_bank.sv
// ============================================================================
// Module      : fft_in_bank
// Description : One frame bank of the FFT input buffer: 2^FFTSIZ x NUBITS
//               register array with a synchronous write port and an
//               asynchronous (combinational) read port.
//               Optional feature macro: none (FFT_IN_BITREV_EN only affects
//               the read address generated in fft_in_buf).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_in_bank
    import fft_in_pkg::*;
#(
    parameter int NUBITS = 32,
    parameter int FFTSIZ = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [FFTSIZ-1:0] waddr,
    input  logic [NUBITS-1:0] wdata,
    input  logic [FFTSIZ-1:0] raddr,
    output logic [NUBITS-1:0] rdata
);

    localparam int c_DEPTH = 1 << FFTSIZ;

    // Storage is not reset: stale contents are never observable because
    // the full flags gate every read of a bank.
    logic [NUBITS-1:0] r_mem [c_DEPTH];

    // Synchronous write of one sample.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule : fft_in_bank

`default_nettype wire

// File: rtl/fft_in_buf.sv
// ============================================================================
// Module      : fft_in_buf
// Description : Ping-pong frame buffer in front of the FFT processor input.
//               Collects frames of 2^FFTSIZ samples from a valid/ready
//               stream into two banks, raises a one-cycle itr pulse when a
//               frame is ready, then serves one word per req_in strobe on
//               io_in. req_in outside of serving sets the sticky und flag.
//               Optional feature macro: FFT_IN_BITREV_EN - when defined the
//               frame is served in FFTSIZ-bit reversed address order.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_in_buf
    import fft_in_pkg::*;
#(
    parameter int NUBITS = 32,
    parameter int FFTSIZ = 3
) (
    input  logic              clk,
    input  logic              rst,       // asynchronous, active-low
    input  logic [NUBITS-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [NUBITS-1:0] io_in,
    input  logic              req_in,
    output logic              itr,
    output logic              und
);

    localparam logic [FFTSIZ-1:0] c_LAST_IDX = {FFTSIZ{1'b1}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]        r_full;
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [FFTSIZ-1:0] r_wr_ptr;
    logic [FFTSIZ-1:0] r_rd_ptr;
    logic              r_und;
    fft_in_state_t     r_state;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    fft_in_state_t     w_state_next;
    logic              w_wr_fire;
    logic              w_wr_last;
    logic              w_rd_fire;
    logic              w_rd_last;
    logic              w_serving;
    logic              w_itr;
    logic [1:0]        w_full_set;
    logic [1:0]        w_full_clr;
    logic [1:0]        w_bank_we;
    logic [FFTSIZ-1:0] w_rd_addr;
    logic [NUBITS-1:0] w_bank_rdata [2];

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    // The writer only ever targets a bank that is not full, so s_ready is a
    // pure function of registered flags and never looks at s_valid.
    assign s_ready   = ~r_full[r_wr_bank];
    assign w_wr_fire = s_valid & s_ready;
    assign w_wr_last = w_wr_fire & (r_wr_ptr == c_LAST_IDX);

    // Write pointer advances per handshake; bank flips on the last word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr  <= '0;
            r_wr_bank <= 1'b0;
        end else if (w_wr_fire) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_wr_last) begin
                r_wr_ptr  <= '0;
                r_wr_bank <= ~r_wr_bank;
            end
        end
    end

    // ------------------------------------------------------------------
    // Full flags
    // ------------------------------------------------------------------
    // Set and clear always target different banks (writer needs an empty
    // bank, reader a full one), so both may apply in the same cycle.
    assign w_full_set = w_wr_last ? (r_wr_bank ? 2'b10 : 2'b01) : 2'b00;
    assign w_full_clr = w_rd_last ? (r_rd_bank ? 2'b10 : 2'b01) : 2'b00;

    // Full flag register: completed frames set, fully read frames clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_full <= 2'b00;
        end else begin
            r_full <= (r_full | w_full_set) & ~w_full_clr;
        end
    end

    // ------------------------------------------------------------------
    // Read-side FSM
    // ------------------------------------------------------------------
    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and read-side decode. IDLE always lasts at least one cycle
    // after a frame completes, which spaces consecutive itr pulses.
    always_comb begin
        w_state_next = r_state;
        w_rd_fire    = 1'b0;
        w_serving    = 1'b0;
        w_itr        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_full[r_rd_bank]) begin
                    w_state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                w_itr        = 1'b1;
                w_state_next = ST_SERVE;
            end
            ST_SERVE: begin
                w_serving = 1'b1;
                if (req_in) begin
                    w_rd_fire = 1'b1;
                    if (r_rd_ptr == c_LAST_IDX) begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_rd_last = w_rd_fire & (r_rd_ptr == c_LAST_IDX);

    // Read pointer advances per strobe in SERVE; bank flips on the last read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr  <= '0;
            r_rd_bank <= 1'b0;
        end else if (w_rd_fire) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_rd_last) begin
                r_rd_ptr  <= '0;
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    // Sticky underrun: any strobe while no frame is being served.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_und <= 1'b0;
        end else if (req_in && !w_serving) begin
            r_und <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Read address ordering
    // ------------------------------------------------------------------
`ifdef FFT_IN_BITREV_EN
    // Bit-reversed order so an in-place DIT FFT can consume the stream.
    assign w_rd_addr = FFTSIZ'(bit_rev(c_BITREV_MAX_W'(r_rd_ptr), FFTSIZ));
`else
    // Natural order.
    assign w_rd_addr = r_rd_ptr;
`endif

    // ------------------------------------------------------------------
    // Frame banks
    // ------------------------------------------------------------------
    generate
        for (genvar b = 0; b < 2; b++) begin : g_bank
            assign w_bank_we[b] = w_wr_fire & (r_wr_bank == 1'(b));

            fft_in_bank #(
                .NUBITS (NUBITS),
                .FFTSIZ (FFTSIZ)
            ) u_bank (
                .clk   (clk),
                .we    (w_bank_we[b]),
                .waddr (r_wr_ptr),
                .wdata (s_data),
                .raddr (w_rd_addr),
                .rdata (w_bank_rdata[b])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign io_in = w_serving ? w_bank_rdata[r_rd_bank] : '0;
    assign itr   = w_itr;
    assign und   = r_und;

endmodule : fft_in_buf

`default_nettype wire

// File: tb/tb_fft_in_buf.sv
// ============================================================================
// Module      : tb_fft_in_buf
// Description : Self-checking bench for fft_in_buf. A queue holds every
//               accepted sample in arrival order; each served frame is the
//               next 8 entries, read in natural or bit-reversed order
//               depending on FFT_IN_BITREV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fft_in_buf;

    localparam int NUBITS = 32;
    localparam int FFTSIZ = 3;
    localparam int N      = 1 << FFTSIZ;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NUBITS-1:0] s_data = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [NUBITS-1:0] io_in;
    logic              req_in = 1'b0;
    logic              itr;
    logic              und;

    int tests_run    = 0;
    int tests_failed = 0;
    int itr_cnt      = 0;

    logic [NUBITS-1:0] model_q [$];

    fft_in_buf #(
        .NUBITS (NUBITS),
        .FFTSIZ (FFTSIZ)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .io_in   (io_in),
        .req_in  (req_in),
        .itr     (itr),
        .und     (und)
    );

    always #5 clk = ~clk;

    // Count interrupt cycles mid-cycle.
    always @(negedge clk) begin
        if (itr === 1'b1) itr_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, run=%0d failed=%0d", tests_run, tests_failed);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Position in the frame of the k-th served word.
    function automatic int addr_of(input int k);
        int r;
`ifdef FFT_IN_BITREV_EN
        r = 0;
        for (int i = 0; i < FFTSIZ; i++) r = r * 2 + ((k >> i) & 1);
`else
        r = k;
`endif
        return r;
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Push 'count' samples (sequential from base, or random).
    task automatic push_words(input int count, input bit use_seq, input int base, input bit chk_ready);
        logic [NUBITS-1:0] d;
        int n;
        for (int i = 0; i < count; i++) begin
            d = use_seq ? NUBITS'(base + i) : NUBITS'($urandom);
            s_valid = 1'b1;
            s_data  = d;
            if (chk_ready) begin
                tests_run++;
                if (s_ready !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL ready_during_push: s_ready=%b expected 1 (word %0d)", s_ready, i);
                end
            end
            n = 0;
            while (s_ready !== 1'b1 && n < 50) begin
                tick();
                n++;
            end
            if (n == 50) begin
                tests_run++;
                tests_failed++;
                $display("FAIL push_timeout: s_ready stayed %b, expected 1", s_ready);
                s_valid = 1'b0;
                return;
            end
            tick();
            model_q.push_back(d);
        end
        s_valid = 1'b0;
    endtask

    // Wait for itr, then step into SERVE.
    task automatic wait_itr(input int budget);
        int n = 0;
        while (itr !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        tests_run++;
        if (itr !== 1'b1) begin
            tests_failed++;
            $display("FAIL itr_timeout: itr=%b expected 1 within %0d cycles", itr, budget);
        end
        tick();
    endtask

    task automatic pop_frame(output logic [NUBITS-1:0] f [N]);
        for (int i = 0; i < N; i++) begin
            if (model_q.size() == 0) begin
                f[i] = 'x;
            end else begin
                f[i] = model_q.pop_front();
            end
        end
    endtask

    // Read a whole frame, one strobe per cycle, checking every word.
    task automatic read_frame(input string name);
        logic [NUBITS-1:0] f [N];
        logic [NUBITS-1:0] exp;
        pop_frame(f);
        for (int k = 0; k < N; k++) begin
            exp = f[addr_of(k)];
            tests_run++;
            if (io_in !== exp) begin
                tests_failed++;
                $display("FAIL %s word %0d: io_in=%h expected %h", name, k, io_in, exp);
            end
            req_in = 1'b1;
            tick();
        end
        req_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_bit("reset_s_ready", s_ready, 1'b1);
        check_bit("reset_itr", itr, 1'b0);
        check_bit("reset_und", und, 1'b0);
        tests_run++;
        if (io_in !== '0) begin
            tests_failed++;
            $display("FAIL reset_io_in: io_in=%h expected 0", io_in);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int c0 = itr_cnt;
        push_words(N, 1'b1, 1, 1'b1);
        check_bit("itr_after_e0", itr, 1'b0);
        tick();
        check_bit("itr_after_e1", itr, 1'b1);
        tick();
        check_bit("itr_after_e2", itr, 1'b0);
        read_frame("basic");
        tests_run++;
        if (itr_cnt - c0 != 1) begin
            tests_failed++;
            $display("FAIL basic_itr_count: got %0d expected 1", itr_cnt - c0);
        end
        tests_run++;
        if (io_in !== '0) begin
            tests_failed++;
            $display("FAIL idle_io_in: io_in=%h expected 0", io_in);
        end
    endtask

    task automatic test_fill_both();
        int c0 = itr_cnt;
        push_words(2 * N, 1'b0, 0, 1'b1);
        check_bit("full_s_ready", s_ready, 1'b0);
        repeat (3) tick();
        check_bit("full_s_ready_hold", s_ready, 1'b0);
        tests_run++;
        if (itr_cnt - c0 != 1) begin
            tests_failed++;
            $display("FAIL fill_itr_count: got %0d expected 1", itr_cnt - c0);
        end
        read_frame("fill_f1");
        check_bit("ready_after_read", s_ready, 1'b1);
        wait_itr(5);
        read_frame("fill_f2");
    endtask

    task automatic test_overlap();
        push_words(N, 1'b0, 0, 1'b1);
        wait_itr(5);
        fork
            read_frame("overlap_a");
            push_words(N, 1'b0, 0, 1'b1);
        join
        wait_itr(5);
        read_frame("overlap_b");
    endtask

    task automatic test_underrun();
        check_bit("und_before", und, 1'b0);
        req_in = 1'b1;
        tick();
        req_in = 1'b0;
        check_bit("und_set", und, 1'b1);
        repeat (3) tick();
        check_bit("und_sticky", und, 1'b1);
        push_words(N, 1'b0, 0, 1'b0);
        wait_itr(5);
        read_frame("after_und");
        check_bit("und_still", und, 1'b1);
    endtask

    task automatic test_reset_mid();
        logic [NUBITS-1:0] f [N];
        int c0;
        push_words(N, 1'b0, 0, 1'b0);
        wait_itr(5);
        push_words(3, 1'b0, 0, 1'b0);
        pop_frame(f);
        for (int k = 0; k < 5; k++) begin
            tests_run++;
            if (io_in !== f[addr_of(k)]) begin
                tests_failed++;
                $display("FAIL partial_read word %0d: io_in=%h expected %h", k, io_in, f[addr_of(k)]);
            end
            req_in = 1'b1;
            tick();
        end
        req_in = 1'b0;
        rst = 1'b0;
        #2;
        check_bit("midrst_s_ready", s_ready, 1'b1);
        check_bit("midrst_itr", itr, 1'b0);
        check_bit("midrst_und", und, 1'b0);
        tests_run++;
        if (io_in !== '0) begin
            tests_failed++;
            $display("FAIL midrst_io_in: io_in=%h expected 0", io_in);
        end
        model_q.delete();
        repeat (2) tick();
        rst = 1'b1;
        c0 = itr_cnt;
        repeat (20) tick();
        tests_run++;
        if (itr_cnt != c0) begin
            tests_failed++;
            $display("FAIL midrst_no_itr: got %0d pulses expected 0", itr_cnt - c0);
        end
        push_words(N - 1, 1'b0, 0, 1'b1);
        repeat (10) tick();
        tests_run++;
        if (itr_cnt != c0) begin
            tests_failed++;
            $display("FAIL midrst_partial_itr: got %0d pulses expected 0", itr_cnt - c0);
        end
        push_words(1, 1'b0, 0, 1'b1);
        wait_itr(5);
        read_frame("after_midrst");
    endtask

    task automatic test_hold_req();
        logic [NUBITS-1:0] f [N];
        push_words(N, 1'b0, 0, 1'b0);
        wait_itr(5);
        pop_frame(f);
        req_in = 1'b1;
        for (int k = 0; k < N; k++) begin
            tests_run++;
            if (io_in !== f[addr_of(k)]) begin
                tests_failed++;
                $display("FAIL hold_read word %0d: io_in=%h expected %h", k, io_in, f[addr_of(k)]);
            end
            tick();
        end
        check_bit("hold_und_clear", und, 1'b0);
        tests_run++;
        if (io_in !== '0) begin
            tests_failed++;
            $display("FAIL hold_idle_io_in: io_in=%h expected 0", io_in);
        end
        tick();
        req_in = 1'b0;
        check_bit("hold_und_set", und, 1'b1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill_both();
        test_overlap();
        test_underrun();
        test_reset_mid();
        test_hold_req();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_fft_in_buf

`default_nettype wire
